// File: rtl/i2c_temp_scheduler_if.sv
// Command/response handshake between the temperature scheduler and the I2C byte engine.
// The scheduler drives commands as master; the byte engine answers as slave.
interface i2c_temp_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );
endinterface

// File: rtl/i2c_temp_scheduler.sv
// ADT7420 read sequencer: pointer write, repeated START, two-byte read, STOP.
// Define TEMP_AUTO_POLL_EN to add a free-running poll tick every POLL_DIV cycles.
module i2c_temp_scheduler #(
    parameter logic [6:0]  DEV_ADDR = 7'h48,
    parameter logic [7:0]  TEMP_REG = 8'h00,
    parameter logic [23:0] POLL_DIV = 24'd1000000
) (
    input  logic                        FSM_Clk,
    input  logic                        reset,
    input  logic                        start_req,
    i2c_temp_scheduler_if.master        bus,
    output logic [7:0]                  temp_msb,
    output logic [7:0]                  temp_lsb,
    output logic                        temp_valid,
    output logic                        busy,
    output logic                        nack_err
);

    localparam logic [2:0] OpStart    = 3'd0;
    localparam logic [2:0] OpWrite    = 3'd1;
    localparam logic [2:0] OpReadAck  = 3'd2;
    localparam logic [2:0] OpReadNack = 3'd3;
    localparam logic [2:0] OpStop     = 3'd4;

    typedef enum logic [3:0] {
        StIdle, StS1, StWa, StWr, StS2, StRa, StRm, StRl, StSp
    } state_e;

    state_e     state_q, next_state;
    logic       cmd_valid_q;
    logic [2:0] cmd_op_q;
    logic [7:0] cmd_wdata_q;
    logic       issued_q;
    logic       seq_err_q;
    logic       pending_q;
    logic       start_q;
    logic [7:0] hold_msb_q, hold_lsb_q;
    logic       poll_tick;
    logic       trigger;

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_wdata = cmd_wdata_q;

`ifdef TEMP_AUTO_POLL_EN
    logic [23:0] poll_cnt_q;

    assign poll_tick = (poll_cnt_q == POLL_DIV - 24'd1);

    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            poll_cnt_q <= '0;
        end else if (poll_tick) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + 24'd1;
        end
    end
`else
    logic unused_poll_div;
    assign unused_poll_div = ^POLL_DIV;
    assign poll_tick       = 1'b0;
`endif

    // A start_req edge and a poll tick in the same cycle are one trigger.
    assign trigger = (start_req & ~start_q) | poll_tick;

    function automatic logic [10:0] cmd_of(state_e st);
        case (st)
            StS1, StS2: cmd_of = {OpStart, 8'h00};
            StWa:       cmd_of = {OpWrite, DEV_ADDR, 1'b0};
            StWr:       cmd_of = {OpWrite, TEMP_REG};
            StRa:       cmd_of = {OpWrite, DEV_ADDR, 1'b1};
            StRm:       cmd_of = {OpReadAck, 8'h00};
            StRl:       cmd_of = {OpReadNack, 8'h00};
            StSp:       cmd_of = {OpStop, 8'h00};
            default:    cmd_of = 11'd0;
        endcase
    endfunction

    always_comb begin
        next_state = StIdle;
        case (state_q)
            StS1:    next_state = StWa;
            StWa:    next_state = StWr;
            StWr:    next_state = StS2;
            StS2:    next_state = StRa;
            StRa:    next_state = StRm;
            StRm:    next_state = StRl;
            StRl:    next_state = StSp;
            default: next_state = StIdle;
        endcase
        if (bus.rsp_nack && (state_q == StWa || state_q == StWr || state_q == StRa)) begin
            next_state = StSp;
        end
    end

    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 3'd0;
            cmd_wdata_q <= 8'd0;
            issued_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
            hold_msb_q  <= 8'd0;
            hold_lsb_q  <= 8'd0;
            temp_msb    <= 8'd0;
            temp_lsb    <= 8'd0;
            temp_valid  <= 1'b0;
            busy        <= 1'b0;
            nack_err    <= 1'b0;
        end else begin
            start_q    <= start_req;
            temp_valid <= 1'b0;
            if (trigger && state_q != StIdle) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (trigger || pending_q) begin
                        state_q     <= StS1;
                        busy        <= 1'b1;
                        pending_q   <= 1'b0;
                        seq_err_q   <= 1'b0;
                        issued_q    <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        {cmd_op_q, cmd_wdata_q} <= cmd_of(StS1);
                    end
                end
                StS1, StWa, StWr, StS2, StRa, StRm, StRl, StSp: begin
                    if (cmd_valid_q && bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        issued_q    <= 1'b1;
                    end else if (issued_q && bus.rsp_valid) begin
                        issued_q <= 1'b0;
                        if (state_q == StRm) hold_msb_q <= bus.rsp_rdata;
                        if (state_q == StRl) hold_lsb_q <= bus.rsp_rdata;
                        if (next_state == StSp && state_q != StRl) begin
                            nack_err  <= 1'b1;
                            seq_err_q <= 1'b1;
                        end
                        if (state_q == StSp) begin
                            state_q     <= StIdle;
                            busy        <= 1'b0;
                            cmd_op_q    <= 3'd0;
                            cmd_wdata_q <= 8'd0;
                            if (!seq_err_q) begin
                                temp_msb   <= hold_msb_q;
                                temp_lsb   <= hold_lsb_q;
                                temp_valid <= 1'b1;
                                nack_err   <= 1'b0;
                            end
                        end else begin
                            state_q     <= next_state;
                            cmd_valid_q <= 1'b1;
                            {cmd_op_q, cmd_wdata_q} <= cmd_of(next_state);
                        end
                    end
                end
                // Illegal encodings fall back to idle without touching the bus.
                default: begin
                    state_q     <= StIdle;
                    cmd_valid_q <= 1'b0;
                    issued_q    <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_temp_scheduler.sv
// Directed bench for i2c_temp_scheduler with a behavioural byte-engine model.
// Poll-tick checks run only when TEMP_AUTO_POLL_EN is defined.
module tb_i2c_temp_scheduler;

    logic       FSM_Clk;
    logic       reset;
    logic       start_req;
    logic [7:0] temp_msb, temp_lsb;
    logic       temp_valid, busy, nack_err;

    i2c_temp_scheduler_if bus ();

    i2c_temp_scheduler #(
        .DEV_ADDR (7'h48),
        .TEMP_REG (8'h00),
        .POLL_DIV (24'd200)
    ) dut (
        .FSM_Clk    (FSM_Clk),
        .reset      (reset),
        .start_req  (start_req),
        .bus        (bus),
        .temp_msb   (temp_msb),
        .temp_lsb   (temp_lsb),
        .temp_valid (temp_valid),
        .busy       (busy),
        .nack_err   (nack_err)
    );

    initial FSM_Clk = 1'b0;
    always #5 FSM_Clk = ~FSM_Clk;

    int nvec = 0;
    int nerr = 0;

    // Byte-engine model configuration, driven from the test tasks.
    logic [7:0] msb_val = 8'h00;
    logic [7:0] lsb_val = 8'h00;
    bit         nack_wa = 1'b0;
    int         ready_hold = 0;

    // Model state and observations, written only by the model process.
    int         cyc = 0;
    int         wait_cnt = 0;
    int         rsp_timer = 0;
    logic [2:0] acc_op = 3'd0;
    logic [7:0] acc_wd = 8'd0;
    bit         prev_wait = 1'b0;
    logic [2:0] prev_op = 3'd0;
    logic [7:0] prev_wd = 8'd0;
    int         stab_err = 0;
    int         overlap_err = 0;
    int         pulses = 0;
    logic       busy_q = 1'b0;
    logic [2:0] log_op[$];
    logic [7:0] log_wd[$];
    int         start_cyc[$];

    assign bus.cmd_ready = bus.cmd_valid && (wait_cnt >= ready_hold);

    always @(posedge FSM_Clk) begin
        cyc           <= cyc + 1;
        bus.rsp_valid <= 1'b0;
        bus.rsp_nack  <= 1'b0;
        bus.rsp_rdata <= 8'd0;
        busy_q        <= busy;
        if (temp_valid === 1'b1) pulses <= pulses + 1;
        if (busy === 1'b1 && busy_q !== 1'b1) start_cyc.push_back(cyc);
        if (reset) begin
            wait_cnt  <= 0;
            rsp_timer <= 0;
            prev_wait <= 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (rsp_timer != 0) overlap_err <= overlap_err + 1;
                if (prev_wait && (bus.cmd_op !== prev_op || bus.cmd_wdata !== prev_wd))
                    stab_err <= stab_err + 1;
                log_op.push_back(bus.cmd_op);
                log_wd.push_back(bus.cmd_wdata);
                acc_op    <= bus.cmd_op;
                acc_wd    <= bus.cmd_wdata;
                rsp_timer <= 2;
                wait_cnt  <= 0;
                prev_wait <= 1'b0;
            end else if (bus.cmd_valid) begin
                wait_cnt <= wait_cnt + 1;
                if (prev_wait && (bus.cmd_op !== prev_op || bus.cmd_wdata !== prev_wd))
                    stab_err <= stab_err + 1;
                prev_wait <= 1'b1;
                prev_op   <= bus.cmd_op;
                prev_wd   <= bus.cmd_wdata;
            end
            if (rsp_timer == 1) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= (acc_op == 3'd2) ? msb_val : (acc_op == 3'd3) ? lsb_val : 8'd0;
                bus.rsp_nack  <= nack_wa && acc_op == 3'd1 && acc_wd == 8'h90;
                rsp_timer     <= 0;
            end else if (rsp_timer > 1) begin
                rsp_timer <= rsp_timer - 1;
            end
        end
    end

    // Expected {op, wdata} for the i-th command of a full read sequence.
    function automatic logic [10:0] exp_cmd(int i);
        case (i)
            0:       exp_cmd = {3'd0, 8'h00};
            1:       exp_cmd = {3'd1, 8'h90};
            2:       exp_cmd = {3'd1, 8'h00};
            3:       exp_cmd = {3'd0, 8'h00};
            4:       exp_cmd = {3'd1, 8'h91};
            5:       exp_cmd = {3'd2, 8'h00};
            6:       exp_cmd = {3'd3, 8'h00};
            default: exp_cmd = {3'd4, 8'h00};
        endcase
    endfunction

    task automatic kick();
        @(negedge FSM_Clk) start_req = 1'b0;
        @(negedge FSM_Clk) start_req = 1'b1;
        @(posedge FSM_Clk);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge FSM_Clk);
            #1;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge FSM_Clk);
        #1;
    endtask

    task automatic check_full_seq(input int base, input string tag);
        logic [10:0] got;
        for (int i = 0; i < 8; i++) begin
            got = {log_op[base+i], log_wd[base+i]};
            nvec++;
            if (got !== exp_cmd(i)) begin
                nerr++;
                $display("FAIL %s_cmd%0d: got op=%0d wdata=%h, want op=%0d wdata=%h", tag, i,
                         got[10:8], got[7:0], exp_cmd(i) >> 8, exp_cmd(i) & 11'hff);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_req = 1'b0;
        repeat (2) @(posedge FSM_Clk);
        #1;
        nvec++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_wdata} !== 12'd0) begin
            nerr++;
            $display("FAIL reset_cmd: got valid=%b op=%0d wdata=%h, want 0/0/00",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_wdata);
        end
        nvec++;
        if ({temp_msb, temp_lsb, temp_valid, busy, nack_err} !== 19'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got msb=%h lsb=%h tv=%b busy=%b nack=%b, want zeros",
                     temp_msb, temp_lsb, temp_valid, busy, nack_err);
        end
        @(negedge FSM_Clk) reset = 1'b0;
    endtask

    task automatic test_read();
        int base = log_op.size();
        int pb = pulses;
        bit ok;
        msb_val = 8'h0C; lsb_val = 8'h80; nack_wa = 1'b0; ready_hold = 0;
        kick();
        nvec++;
        if ({busy, bus.cmd_valid, bus.cmd_op} !== 5'b11_000) begin
            nerr++;
            $display("FAIL read_launch: got busy=%b valid=%b op=%0d, want 1/1/0",
                     busy, bus.cmd_valid, bus.cmd_op);
        end
        wait_idle(400, ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL read_timeout: busy still 1, want 0"); end
        settle();
        nvec++;
        if (log_op.size() - base !== 8) begin
            nerr++;
            $display("FAIL read_count: got %0d commands, want 8", log_op.size() - base);
        end else begin
            check_full_seq(base, "read");
        end
        nvec++;
        if ({temp_msb, temp_lsb} !== 16'h0C80) begin
            nerr++;
            $display("FAIL read_temp: got %h%h, want 0c80", temp_msb, temp_lsb);
        end
        nvec++;
        if (pulses - pb !== 1) begin
            nerr++;
            $display("FAIL read_pulses: got %0d temp_valid pulses, want 1", pulses - pb);
        end
        nvec++;
        if (nack_err !== 1'b0) begin nerr++; $display("FAIL read_nack: got %b, want 0", nack_err); end
    endtask

    task automatic test_nack();
        int base = log_op.size();
        int pb = pulses;
        bit ok;
        msb_val = 8'h55; lsb_val = 8'hAA; nack_wa = 1'b1; ready_hold = 0;
        kick();
        wait_idle(400, ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL nack_timeout: busy still 1, want 0"); end
        settle();
        nvec++;
        if (log_op.size() - base !== 3) begin
            nerr++;
            $display("FAIL nack_count: got %0d commands, want 3", log_op.size() - base);
        end else begin
            nvec++;
            if ({log_op[base], log_wd[base], log_op[base+1], log_wd[base+1],
                 log_op[base+2], log_wd[base+2]} !== {3'd0, 8'h00, 3'd1, 8'h90, 3'd4, 8'h00}) begin
                nerr++;
                $display("FAIL nack_order: got %0d/%h %0d/%h %0d/%h, want 0/00 1/90 4/00",
                         log_op[base], log_wd[base], log_op[base+1], log_wd[base+1],
                         log_op[base+2], log_wd[base+2]);
            end
        end
        nvec++;
        if (nack_err !== 1'b1) begin nerr++; $display("FAIL nack_flag: got %b, want 1", nack_err); end
        nvec++;
        if ({temp_msb, temp_lsb} !== 16'h0C80) begin
            nerr++;
            $display("FAIL nack_temp: got %h%h, want 0c80", temp_msb, temp_lsb);
        end
        nvec++;
        if (pulses - pb !== 0) begin
            nerr++;
            $display("FAIL nack_pulses: got %0d temp_valid pulses, want 0", pulses - pb);
        end
        nack_wa = 1'b0;
    endtask

    task automatic test_stall();
        int base = log_op.size();
        int pb = pulses;
        int se = stab_err;
        bit ok;
        msb_val = 8'h19; lsb_val = 8'h40; nack_wa = 1'b0; ready_hold = 5;
        kick();
        wait_idle(800, ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL stall_timeout: busy still 1, want 0"); end
        settle();
        nvec++;
        if (stab_err - se !== 0) begin
            nerr++;
            $display("FAIL stall_stable: got %0d unstable cycles, want 0", stab_err - se);
        end
        nvec++;
        if (log_op.size() - base !== 8) begin
            nerr++;
            $display("FAIL stall_count: got %0d commands, want 8", log_op.size() - base);
        end else begin
            check_full_seq(base, "stall");
        end
        nvec++;
        if ({temp_msb, temp_lsb, nack_err} !== {16'h1940, 1'b0}) begin
            nerr++;
            $display("FAIL stall_result: got %h%h nack=%b, want 1940 nack=0",
                     temp_msb, temp_lsb, nack_err);
        end
        nvec++;
        if (pulses - pb !== 1) begin
            nerr++;
            $display("FAIL stall_pulses: got %0d, want 1", pulses - pb);
        end
        ready_hold = 0;
    endtask

    task automatic test_back_to_back();
        int base = log_op.size();
        int pb = pulses;
        bit ok;
        msb_val = 8'h21; lsb_val = 8'h08; ready_hold = 0;
        kick();
        for (int k = 0; k < 3; k++) begin
            @(negedge FSM_Clk) start_req = 1'b0;
            @(negedge FSM_Clk) start_req = 1'b1;
        end
        wait_idle(400, ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL b2b_timeout1: busy still 1, want 0"); end
        @(posedge FSM_Clk);
        #1;
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_restart: got busy=%b, want 1", busy); end
        wait_idle(400, ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL b2b_timeout2: busy still 1, want 0"); end
        repeat (60) @(posedge FSM_Clk);
        #1;
        nvec++;
        if (log_op.size() - base !== 16) begin
            nerr++;
            $display("FAIL b2b_count: got %0d commands, want 16", log_op.size() - base);
        end else begin
            check_full_seq(base + 8, "b2b");
        end
        nvec++;
        if (pulses - pb !== 2) begin
            nerr++;
            $display("FAIL b2b_pulses: got %0d, want 2", pulses - pb);
        end
        nvec++;
        if ({temp_msb, temp_lsb} !== 16'h2108) begin
            nerr++;
            $display("FAIL b2b_temp: got %h%h, want 2108", temp_msb, temp_lsb);
        end
        nvec++;
        if (overlap_err !== 0) begin
            nerr++;
            $display("FAIL b2b_overlap: got %0d overlapping commands, want 0", overlap_err);
        end
    endtask

    task automatic test_reset_mid();
        int base = log_op.size();
        bit found = 1'b0;
        kick();
        for (int i = 0; i < 300; i++) begin
            @(negedge FSM_Clk);
            if (bus.cmd_valid === 1'b1 && bus.cmd_op === 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        nvec++;
        if (!found) begin nerr++; $display("FAIL rstmid_reach: READ_ACK never issued, want issued"); end
        reset = 1'b1;
        start_req = 1'b0;
        @(posedge FSM_Clk);
        #1;
        nvec++;
        if ({bus.cmd_valid, busy, bus.cmd_op, bus.cmd_wdata} !== 13'd0) begin
            nerr++;
            $display("FAIL rstmid_bus: got valid=%b busy=%b op=%0d wdata=%h, want zeros",
                     bus.cmd_valid, busy, bus.cmd_op, bus.cmd_wdata);
        end
        nvec++;
        if ({temp_msb, temp_lsb, temp_valid, nack_err} !== 18'd0) begin
            nerr++;
            $display("FAIL rstmid_outputs: got msb=%h lsb=%h tv=%b nack=%b, want zeros",
                     temp_msb, temp_lsb, temp_valid, nack_err);
        end
        @(negedge FSM_Clk) reset = 1'b0;
        repeat (40) @(posedge FSM_Clk);
        #1;
        nvec++;
        if (log_op.size() - base !== 5) begin
            nerr++;
            $display("FAIL rstmid_nostop: got %0d commands, want 5", log_op.size() - base);
        end
    endtask

    task automatic test_poll();
        int sb = start_cyc.size();
        msb_val = 8'h11; lsb_val = 8'h22; ready_hold = 0;
        repeat (1100) @(posedge FSM_Clk);
        #1;
        nvec++;
        if (start_cyc.size() - sb < 5) begin
            nerr++;
            $display("FAIL poll_count: got %0d sequences, want at least 5", start_cyc.size() - sb);
        end else begin
            for (int i = sb + 1; i < start_cyc.size(); i++) begin
                nvec++;
                if (start_cyc[i] - start_cyc[i-1] !== 200) begin
                    nerr++;
                    $display("FAIL poll_period%0d: got %0d cycles, want 200", i - sb,
                             start_cyc[i] - start_cyc[i-1]);
                end
            end
        end
        nvec++;
        if ({temp_msb, temp_lsb} !== 16'h1122) begin
            nerr++;
            $display("FAIL poll_temp: got %h%h, want 1122", temp_msb, temp_lsb);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_req = 1'b0;
        test_reset();
`ifdef TEMP_AUTO_POLL_EN
        test_poll();
`else
        test_read();
        test_nack();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
